// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32 load/store unit front-end; aligns sub-word accesses onto a
// word-wide memory handshake and returns lane-0 aligned load data.
module lsu_mem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        ld_valid_o,
    output logic [31:0] ld_data_o,
    output logic [3:0]  mask_o,
    output logic        unsign_o,
    output logic        err_o,
    output logic        busy_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    // The final RESP cycle is the one whose increment would reach TIMEOUT.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [2:0]    r_f3;
    logic [1:0]    r_off;
    logic [3:0]    w_mask;
    logic [3:0]    w_ld_mask;
    logic          w_illegal;

    assign w_mask    = req_funct3_i[1:0] == 2'b00 ? 4'b0001 :
                       req_funct3_i[1:0] == 2'b01 ? 4'b0011 :
                       req_funct3_i[1:0] == 2'b10 ? 4'b1111 : 4'b0000;
    assign w_ld_mask = r_f3[1:0] == 2'b00 ? 4'b0001 :
                       r_f3[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
    assign w_illegal = req_funct3_i == 3'b011 || req_funct3_i == 3'b110 ||
                       req_funct3_i == 3'b111 ||
                       (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                       (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);

    assign req_ready_o = r_state == IDLE;
    assign busy_o      = r_state != IDLE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_f3        <= 3'b000;
            r_off       <= 2'b00;
            mem_valid_o <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
            ld_valid_o  <= 1'b0;
            ld_data_o   <= '0;
            mask_o      <= '0;
            unsign_o    <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            ld_valid_o <= 1'b0;
            err_o      <= 1'b0;
            case (r_state)
                IDLE: if (req_valid_i) begin
                    if (w_illegal) begin
                        err_o <= 1'b1;
                    end else begin
                        r_we        <= req_we_i;
                        r_f3        <= req_funct3_i;
                        r_off       <= req_addr_i[1:0];
                        mem_valid_o <= 1'b1;
                        mem_we_o    <= req_we_i;
                        mem_addr_o  <= {req_addr_i[31:2], 2'b00};
                        mem_be_o    <= w_mask << req_addr_i[1:0];
                        mem_wdata_o <= req_wdata_i << {req_addr_i[1:0], 3'b000};
                        r_state     <= REQ;
                    end
                end
                REQ: if (mem_ready_i) begin
                    mem_valid_o <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= r_we ? IDLE : RESP;
                end
                RESP: if (mem_rvalid_i) begin
                    ld_valid_o <= 1'b1;
                    ld_data_o  <= mem_rdata_i >> {r_off, 3'b000};
                    mask_o     <= w_ld_mask;
                    unsign_o   <= r_f3[2];
                    r_state    <= IDLE;
                end else if (r_cnt == LAST) begin
                    err_o   <= 1'b1;
                    r_state <= IDLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scoreboard bench for lsu_mem_ctrl (TIMEOUT=4).
module tb_lsu_mem_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0]  req_f3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        mem_valid, mem_ready = 1'b0, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        ld_valid, unsign, err, busy;
    logic [31:0] ld_data;
    logic [3:0]  mask;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        uns;
    } exp_t;
    exp_t q[$];

    lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .ld_valid_o(ld_valid), .ld_data_o(ld_data), .mask_o(mask),
        .unsign_o(unsign), .err_o(err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] f_mask(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 4'b0001 : f3[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
    endfunction

    function automatic bit f_illegal(input logic [2:0] f3, input logic [31:0] a);
        return f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 ||
               (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
    endfunction

    always @(negedge clk) begin
        if (rst_n && (ld_valid || err)) begin
            if (q.size() == 0) begin
                check("unexpected_evt", {30'd0, ld_valid, err}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("err", {31'd0, err}, {31'd0, e.err});
                check("ld_valid", {31'd0, ld_valid}, {31'd0, !e.err});
                if (!e.err) begin
                    check("ld_data", ld_data, e.data);
                    check("mask", {28'd0, mask}, {28'd0, e.mask});
                    check("unsign", {31'd0, unsign}, {31'd0, e.uns});
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        check("drain", q.size(), 0);
    endtask

    // rd: RESP cycle index at which rvalid is driven (out of range -> none inside window)
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int rdy, input int rd,
                         input logic [31:0] rdata);
        bit   ill, ok;
        logic [1:0] off;
        exp_t e;
        ill = f_illegal(f3, a);
        off = a[1:0];
        ok  = rd >= 0 && rd < TO;
        @(negedge clk);
        check("req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
        if (ill || !we) begin
            e.err  = ill || !ok;
            e.data = rdata >> (8 * off);
            e.mask = f_mask(f3);
            e.uns  = f3[2];
            q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (ill) begin
            check("ill_mem_valid", {31'd0, mem_valid}, 32'd0);
            check("ill_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
            check("ill_mem_valid2", {31'd0, mem_valid}, 32'd0);
        end else begin
            for (int i = 0; i <= rdy; i++) begin
                check("mem_valid", {31'd0, mem_valid}, 32'd1);
                check("mem_we", {31'd0, mem_we}, {31'd0, we});
                check("mem_addr", mem_addr, {a[31:2], 2'b00});
                check("mem_be", {28'd0, mem_be}, {28'd0, f_mask(f3) << off});
                check("mem_wdata", mem_wdata, wd << (8 * off));
                check("busy", {31'd0, busy}, 32'd1);
                if (i == rdy) mem_ready = 1'b1;
                @(negedge clk);
            end
            mem_ready = 1'b0;
            check("mem_valid_drop", {31'd0, mem_valid}, 32'd0);
            if (we) begin
                check("store_idle", {31'd0, busy}, 32'd0);
            end else begin
                for (int k = 0; k < TO + 2; k++) begin
                    if (k == rd) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
                    @(negedge clk);
                    mem_rvalid = 1'b0;
                    if (k == rd && ok) check("ld_latency", {31'd0, ld_valid}, 32'd1);
                end
            end
        end
        drain();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_ld_valid", {31'd0, ld_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);

        do_op(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80AA_BBCC);
        do_op(1'b1, 3'b001, 32'h202, 32'h1234_5678, 0, 0, 32'h0);
        check("hold_data", ld_data, 32'h0000_0080);
        check("hold_mask", {28'd0, mask}, 32'h1);
        do_op(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0);
        do_op(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0);
        do_op(1'b1, 3'b001, 32'h001, 32'h0, 0, 0, 32'h0);
        do_op(1'b0, 3'b101, 32'h002, 32'h0, 5, 1, 32'hFFEE_DDCC);
        do_op(1'b0, 3'b010, 32'h040, 32'h0, 0, -1, 32'h0);
        do_op(1'b0, 3'b010, 32'h044, 32'h0, 0, TO - 1, 32'hDEAD_BEEF);
        do_op(1'b0, 3'b100, 32'h001, 32'h0, 1, TO + 1, 32'h1234_5678);
        do_op(1'b1, 3'b000, 32'h003, 32'hA5, 2, 0, 32'h0);
        do_op(1'b0, 3'b001, 32'h002, 32'h0, 0, 2, 32'h8001_0000);

        // reset during RESP: async clear, late rvalid ignored
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h80;
        @(negedge clk);
        req_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ld_data", ld_data, 32'd0);
        check("arst_mask", {28'd0, mask}, 32'd0);
        check("arst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_ld", ld_data, 32'd0);
        do_op(1'b0, 3'b010, 32'h80, 32'h0, 0, 0, 32'h1357_9BDF);

        for (int n = 0; n < 25; n++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            do_op(1'($urandom_range(0, 1)), f3, a, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, TO + 1), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the max cycles waited for load data before error.
REQ-002 clk_i  in  1  single clock; all state SHALL update on rising edge.
REQ-003 rst_ni  in  1  reset SHALL be asynchronous and active-low.
REQ-004 req_valid_i  in  1  pipeline presents a load/store.
REQ-005 req_ready_o  out  1  block accepts request (high only in IDLE).
REQ-006 req_we_i  in  1  1=store, 0=load.
REQ-007 req_funct3_i  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr_i  in  32  byte address.
REQ-009 req_wdata_i  in  32  store data, lane-0 aligned.
REQ-010 mem_valid_o / mem_ready_i  out/in  1/1  memory request handshake.
REQ-011 mem_we_o  out  1; mem_addr_o  out  32 (bits[1:0]=00); mem_be_o  out  4; mem_wdata_o  out  32.
REQ-012 mem_rvalid_i  in  1; mem_rdata_i  in  32  load response, word-aligned.
REQ-013 ld_valid_o  out  1  one-cycle pulse, load result ready.
REQ-014 ld_data_o  out  32  loaded word shifted to lane 0 (unextended).
REQ-015 mask_o  out  4  0001 B, 0011 H, 1111 W, for downstream extension mux.
REQ-016 unsign_o  out  1  equals latched funct3[2].
REQ-017 err_o  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout.
REQ-018 busy_o  out  1  high whenever state is not IDLE (pipeline stall).

Function
REQ-019 FSM states SHALL be IDLE, REQ, RESP.
REQ-020 IDLE: on req_valid_i&&req_ready_o, block SHALL latch we, funct3, addr, wdata and go to REQ, unless request is illegal.
REQ-021 Illegal = funct3 in {011,110,111}, or H/HU with addr[0]=1, or W with addr[1:0]!=00; SHALL pulse err_o next cycle, stay IDLE, issue no memory access.
REQ-022 REQ: mem_valid_o=1 with stable mem_* outputs until mem_ready_i sampled high; then store -> IDLE, load -> RESP.
REQ-023 mem_addr_o SHALL be {addr[31:2],2'b00}; mem_be_o SHALL be mask << addr[1:0]; mem_wdata_o SHALL be wdata << 8*addr[1:0].
REQ-024 RESP: on mem_rvalid_i, ld_data_o SHALL register mem_rdata_i >> 8*addr[1:0], ld_valid_o pulses next cycle, FSM -> IDLE.
REQ-025 mem_rvalid_i outside RESP SHALL be ignored.
REQ-026 RESP cycle counter (width ceil(log2(TIMEOUT+1))) SHALL clear on entry; at count==TIMEOUT without rvalid, err_o pulses, FSM -> IDLE, no ld_valid_o.
REQ-027 rvalid in the same cycle counter reaches TIMEOUT SHALL count as success, not error.
REQ-028 ld_data_o, mask_o, unsign_o SHALL hold last load's values until next load completes.
REQ-029 Minimum load latency: accept cycle N, mem_valid_o at N+1, ready at N+1, rvalid at N+2, ld_valid_o at N+3.

Reset
REQ-030 On rst_ni low, FSM=IDLE, counter=0, all outputs 0 except req_ready_o=1 after reset release; applies immediately, including mid-transaction.
REQ-031 A transaction interrupted by reset SHALL be dropped; no ld_valid_o or err_o afterwards.

Verification
REQ-032 LB addr 0x103, rdata 0x80AA_BBCC -> mem_be_o 1000, ld_data_o 0x0000_0080, mask_o 0001, unsign_o 0.
REQ-033 SH addr 0x202, wdata 0x1234_5678 -> mem_addr_o 0x200, mem_be_o 1100, mem_wdata_o 0x5678_0000.
REQ-034 LW addr 0x101 -> err_o pulse, mem_valid_o never high, busy_o stays 0.
REQ-035 LHU with mem_ready_i held low 5 cycles -> mem_valid_o and outputs stable 6 cycles; rdata 0xFFEE_DDCC at addr 0x2 -> ld_data_o 0x0000_FFEE, unsign_o 1.
REQ-036 TIMEOUT=4, load, no rvalid -> err_o pulse after 4 RESP cycles; rvalid on 4th cycle -> ld_valid_o, no err_o.
REQ-037 rst_ni low during RESP -> outputs 0 asynchronously; late rvalid ignored; next load completes normally.
